// File: rtl/dpram_arb.sv
// dpram_arb: lets two clients (A, B) share a single-clock simple dual-port RAM.
// The read and write ports are arbitrated separately, so one read and one write can be served
// in the same cycle. Each port has its own round-robin priority bit. Reads have a fixed 3-cycle
// latency and return data with a per-client valid strobe. A read and a write to the same
// address in the same cycle can be forwarded (FWD = 1). All RAM-side outputs are registered.
//
// Ports
//   clk, rst_n             single clock, synchronous active-low reset
//   x_req/x_we/x_addr/     client x request (x = a, b); held stable until granted
//   x_wdata
//   x_gnt                  combinational grant; access accepted on req & gnt at the clk edge
//   x_rvalid/x_rdata       one-cycle read-data strobe and registered read data
//   ram_rd_addr            registered RAM read address
//   ram_rd_data            RAM read data (synchronous read, one cycle after ram_rd_addr)
//   ram_wr_addr/data/en    registered RAM write port
module dpram_arb #(
    parameter int unsigned ASZ = 10,
    parameter int unsigned DSZ = 16,
    parameter bit          FWD = 1'b1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           a_req,
    input  logic           a_we,
    input  logic [ASZ-1:0] a_addr,
    input  logic [DSZ-1:0] a_wdata,
    output logic           a_gnt,
    output logic           a_rvalid,
    output logic [DSZ-1:0] a_rdata,
    input  logic           b_req,
    input  logic           b_we,
    input  logic [ASZ-1:0] b_addr,
    input  logic [DSZ-1:0] b_wdata,
    output logic           b_gnt,
    output logic           b_rvalid,
    output logic [DSZ-1:0] b_rdata,
    output logic [ASZ-1:0] ram_rd_addr,
    input  logic [DSZ-1:0] ram_rd_data,
    output logic [ASZ-1:0] ram_wr_addr,
    output logic [DSZ-1:0] ram_wr_data,
    output logic           ram_wr_en
);

    typedef enum logic {PriA = 1'b0, PriB = 1'b1} pri_e;

    // Read tag travelling alongside the RAM access; id 0 = A, 1 = B.
    typedef struct packed {
        logic           valid;
        logic           id;
        logic           hit;
        logic [DSZ-1:0] data;
    } tag_t;

    pri_e           rd_pri_q, rd_pri_d;
    pri_e           wr_pri_q, wr_pri_d;
    logic           a_rd_cand, b_rd_cand, a_wr_cand, b_wr_cand;
    logic           a_rd_gnt, b_rd_gnt, a_wr_gnt, b_wr_gnt;
    logic           rd_acc, wr_acc;
    logic [ASZ-1:0] rd_addr_sel, wr_addr_sel;
    logic [DSZ-1:0] wr_data_sel, rdata_sel;
    tag_t           tag1_d, tag1_q, tag2_q;

    logic [ASZ-1:0] rd_addr_q, wr_addr_q;
    logic [DSZ-1:0] wr_data_q;
    logic           wr_en_q;
    logic           a_rvalid_q, b_rvalid_q;
    logic [DSZ-1:0] a_rdata_q, b_rdata_q;

    always_comb begin
        // Gating with rst_n keeps the grants low during reset.
        a_rd_cand = rst_n & a_req & ~a_we;
        b_rd_cand = rst_n & b_req & ~b_we;
        a_wr_cand = rst_n & a_req & a_we;
        b_wr_cand = rst_n & b_req & b_we;

        a_rd_gnt = a_rd_cand & (~b_rd_cand | (rd_pri_q == PriA));
        b_rd_gnt = b_rd_cand & (~a_rd_cand | (rd_pri_q == PriB));
        a_wr_gnt = a_wr_cand & (~b_wr_cand | (wr_pri_q == PriA));
        b_wr_gnt = b_wr_cand & (~a_wr_cand | (wr_pri_q == PriB));

        a_gnt  = a_rd_gnt | a_wr_gnt;
        b_gnt  = b_rd_gnt | b_wr_gnt;
        rd_acc = a_rd_gnt | b_rd_gnt;
        wr_acc = a_wr_gnt | b_wr_gnt;

        // The winner hands priority to the other client.
        rd_pri_d = rd_pri_q;
        if (a_rd_gnt) begin
            rd_pri_d = PriB;
        end else if (b_rd_gnt) begin
            rd_pri_d = PriA;
        end
        wr_pri_d = wr_pri_q;
        if (a_wr_gnt) begin
            wr_pri_d = PriB;
        end else if (b_wr_gnt) begin
            wr_pri_d = PriA;
        end

        rd_addr_sel = a_rd_gnt ? a_addr : b_addr;
        wr_addr_sel = a_wr_gnt ? a_addr : b_addr;
        wr_data_sel = a_wr_gnt ? a_wdata : b_wdata;

        // A same-cycle write lands in the RAM on the same edge that samples the read,
        // so the RAM returns old data; the tag carries the new data for forwarding.
        tag1_d.valid = rd_acc;
        tag1_d.id    = b_rd_gnt;
        tag1_d.hit   = rd_acc & wr_acc & (rd_addr_sel == wr_addr_sel);
        tag1_d.data  = wr_data_sel;

        rdata_sel = (FWD && tag2_q.hit) ? tag2_q.data : ram_rd_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_pri_q   <= PriA;
            wr_pri_q   <= PriA;
            rd_addr_q  <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            wr_en_q    <= 1'b0;
            tag1_q     <= '0;
            tag2_q     <= '0;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
            a_rdata_q  <= '0;
            b_rdata_q  <= '0;
        end else begin
            rd_pri_q <= rd_pri_d;
            wr_pri_q <= wr_pri_d;
            if (rd_acc) begin
                rd_addr_q <= rd_addr_sel;
            end
            wr_en_q <= wr_acc;
            if (wr_acc) begin
                wr_addr_q <= wr_addr_sel;
                wr_data_q <= wr_data_sel;
            end
            tag1_q     <= tag1_d;
            tag2_q     <= tag1_q;
            a_rvalid_q <= tag2_q.valid & ~tag2_q.id;
            b_rvalid_q <= tag2_q.valid & tag2_q.id;
            if (tag2_q.valid && !tag2_q.id) begin
                a_rdata_q <= rdata_sel;
            end
            if (tag2_q.valid && tag2_q.id) begin
                b_rdata_q <= rdata_sel;
            end
        end
    end

    assign ram_rd_addr = rd_addr_q;
    assign ram_wr_addr = wr_addr_q;
    assign ram_wr_data = wr_data_q;
    assign ram_wr_en   = wr_en_q;
    assign a_rvalid    = a_rvalid_q;
    assign b_rvalid    = b_rvalid_q;
    assign a_rdata     = a_rdata_q;
    assign b_rdata     = b_rdata_q;

endmodule
